shared_round_key_reverse_buffer: RTL



---
 rtl/srkb_pkg.sv | 22 ++
 rtl/shared_rk_regfile.sv | 30 +++
 rtl/shared_round_key_reverse_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/srkb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srkb_pkg
// Brief    : Shared constants and state encoding for the shared round-key
//            reverse buffer.
// Revision : 1.0 - initial release
// ============================================================================
package srkb_pkg;

    localparam int NUM_RK = 17;
    localparam int KEY_W  = 128;
    localparam int PTR_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } srkb_state_e;

endpackage : srkb_pkg
`default_nettype wire

// File: rtl/shared_rk_regfile.sv
`default_nettype none
// ============================================================================
// Module   : shared_rk_regfile
// Brief    : Storage for one key share: synchronous write port and a
//            combinational read port. Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module shared_rk_regfile
    import srkb_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [KEY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [KEY_W-1:0] rdata_o
);

    logic [KEY_W-1:0] mem_q [NUM_RK];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : shared_rk_regfile
`default_nettype wire

// File: rtl/shared_round_key_reverse_buffer.sv
`default_nettype none
// ============================================================================
// Module   : shared_round_key_reverse_buffer
// Brief    : Captures 2-share round keys in generation order and replays them
//            last-first. Shares use separate storage and output registers.
// Revision : 1.0 - initial release
// ============================================================================
module shared_round_key_reverse_buffer
    import srkb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_start,
    input  logic             rk_in_valid,
    input  logic [KEY_W-1:0] rk_in0,
    input  logic [KEY_W-1:0] rk_in1,
    input  logic             rd_start,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic             rd_last,
    output logic [KEY_W-1:0] rd_key0,
    output logic [KEY_W-1:0] rd_key1,
    output logic             full,
    output logic             busy
);

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_RK - 1);

    srkb_state_e      state_q,    state_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic             full_q,     full_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q,  rd_last_d;
    logic [KEY_W-1:0] rd_key0_q,  rd_key0_d;
    logic [KEY_W-1:0] rd_key1_q,  rd_key1_d;

    logic             w_we;
    logic [PTR_W-1:0] w_raddr;
    logic [KEY_W-1:0] w_rdata0;
    logic [KEY_W-1:0] w_rdata1;

    // Read address is control-only; READY always pre-addresses the last entry
    // so the first key can be loaded on the rd_start edge.
    assign w_we    = ~wr_start & rk_in_valid & (state_q == ST_FILL);
    assign w_raddr = (state_q == ST_READY) ? c_last_idx : rd_ptr_q;

    shared_rk_regfile u_share0 (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (rk_in0),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata0)
    );

    shared_rk_regfile u_share1 (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (rk_in1),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_key0_q  <= '0;
            rd_key1_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_key0_q  <= rd_key0_d;
            rd_key1_q  <= rd_key1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        full_d     = full_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_key0_d  = rd_key0_q;
        rd_key1_d  = rd_key1_q;

        if (wr_start) begin
            state_d    = ST_FILL;
            wr_ptr_d   = '0;
            full_d     = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_key0_d  = '0;
            rd_key1_d  = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (rk_in_valid) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == c_last_idx) begin
                            state_d = ST_READY;
                            full_d  = 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (rd_start) begin
                        state_d    = ST_DRAIN;
                        rd_valid_d = 1'b1;
                        rd_last_d  = 1'b0;
                        rd_key0_d  = w_rdata0;
                        rd_key1_d  = w_rdata1;
                        rd_ptr_d   = c_last_idx - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (rd_valid_q && rd_ready) begin
                        if (!rd_last_q) begin
                            rd_key0_d = w_rdata0;
                            rd_key1_d = w_rdata1;
                            rd_last_d = (rd_ptr_q == '0);
                            // Pointer parks at 0 rather than wrapping.
                            if (rd_ptr_q != '0) begin
                                rd_ptr_d = rd_ptr_q - 1'b1;
                            end
                        end else begin
                            state_d    = ST_READY;
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            rd_key0_d  = '0;
                            rd_key1_d  = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_key0  = rd_key0_q;
    assign rd_key1  = rd_key1_q;
    assign full     = full_q;
    assign busy     = (state_q == ST_FILL) | (state_q == ST_DRAIN);

endmodule : shared_round_key_reverse_buffer
`default_nettype wire
